systolic_tile_sequencer: RTL

//  Parametrised controller for the ROWSxROWS systolic array and shared single-port SRAM.
//  Per job, loads ROWS weight rows once, then streams NUM_TILES input tiles of ROWS rows each.

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/seq_row_counter.sv | 41 ++++
 rtl/systolic_tile_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile sequencer: default sizes,
// FSM state codes and SRAM control polarities.
package systolic_pkg;

    localparam int DEF_ROWS = 16;
    localparam int DEF_AW   = 13;
    localparam int DEF_TW   = 8;
    localparam int DEF_RIW  = $clog2(DEF_ROWS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_LOAD_I  = 3'd2,
        S_DRAIN   = 3'd3,
        S_WRITE_O = 3'd4,
        S_DONE    = 3'd5
    } seq_state_e;

    // SRAM control lines are active-low.
    localparam logic CEN_ON    = 1'b0;
    localparam logic CEN_OFF   = 1'b1;
    localparam logic WEN_WRITE = 1'b0;
    localparam logic WEN_READ  = 1'b1;

endpackage

// File: rtl/seq_row_counter.sv
// Small up-counter with clear, increment, enable and terminal-count compare.
// Ports: clk, rst (sync, active-high), en, clr, inc, tc_val -> cnt, tc.
module seq_row_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (clr) begin
                cnt_d = '0;
            end else if (inc) begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == tc_val);

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Job sequencer for a ROWSxROWS systolic array sharing one single-port SRAM:
// loads weights once, then per tile streams activations, drains and writes results.
// Inputs: CLK, RESET (sync, high), EN (stall), START, IADDR/WADDR/OADDR, NUM_TILES.
// Outputs: STATE, BUSY, DONE, share_cen/wen/addr, W_EN, W_ROW, A_VALID, O_SEL.
// Option SEQ_PERF_CNT_EN adds PERF_CYCLES: saturating count of busy enabled cycles.
module systolic_tile_sequencer
    import systolic_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int AW        = DEF_AW,
    parameter int TW        = DEF_TW,
    parameter int ARRAY_LAT = 2 * ROWS - 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    EN,
    input  logic                    START,
    input  logic [AW-1:0]           IADDR,
    input  logic [AW-1:0]           WADDR,
    input  logic [AW-1:0]           OADDR,
    input  logic [TW-1:0]           NUM_TILES,
    output logic [2:0]              STATE,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    share_cen,
    output logic                    share_wen,
    output logic [AW-1:0]           share_addr,
    output logic                    W_EN,
    output logic [$clog2(ROWS)-1:0] W_ROW,
    output logic                    A_VALID,
    output logic [$clog2(ROWS)-1:0] O_SEL
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]             PERF_CYCLES
`endif
);

    localparam int RIW = $clog2(ROWS);
    localparam int DW  = $clog2(ARRAY_LAT) + 1;
    localparam logic [RIW-1:0] ROW_LAST = RIW'(ROWS - 1);
    localparam logic [DW-1:0]  LAT_LAST = DW'(ARRAY_LAT - 1);

    seq_state_e state_q, state_d;
    logic [AW-1:0]  iaddr_q, iaddr_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [AW-1:0]  oaddr_q, oaddr_d;
    logic [TW-1:0]  ntiles_q, ntiles_d;
    logic           w_pend_q, w_pend_d;
    logic [RIW-1:0] w_row_q, w_row_d;
    logic           a_pend_q, a_pend_d;

    logic row_clr, row_inc, row_last;
    logic tile_clr, tile_inc, tile_last;
    logic drn_clr, drn_inc, drn_last;
    logic [RIW-1:0] row_cnt;
    logic [TW-1:0]  tile_cnt;
    logic [DW-1:0]  drn_cnt_unused;
    logic [AW-1:0]  offset;

    seq_row_counter #(.W(RIW)) u_row (
        .clk(CLK), .rst(RESET), .en(EN), .clr(row_clr), .inc(row_inc),
        .tc_val(ROW_LAST), .cnt(row_cnt), .tc(row_last)
    );

    seq_row_counter #(.W(TW)) u_tile (
        .clk(CLK), .rst(RESET), .en(EN), .clr(tile_clr), .inc(tile_inc),
        .tc_val(ntiles_q - TW'(1)), .cnt(tile_cnt), .tc(tile_last)
    );

    seq_row_counter #(.W(DW)) u_drain (
        .clk(CLK), .rst(RESET), .en(EN), .clr(drn_clr), .inc(drn_inc),
        .tc_val(LAT_LAST), .cnt(drn_cnt_unused), .tc(drn_last)
    );

    // ROWS is a power of two, so tile*ROWS+row is a plain concatenation.
    assign offset = AW'({tile_cnt, row_cnt});

    always_comb begin
        state_d    = state_q;
        iaddr_d    = iaddr_q;
        waddr_d    = waddr_q;
        oaddr_d    = oaddr_q;
        ntiles_d   = ntiles_q;
        w_pend_d   = w_pend_q;
        w_row_d    = w_row_q;
        a_pend_d   = a_pend_q;
        row_clr    = 1'b0;
        row_inc    = 1'b0;
        tile_clr   = 1'b0;
        tile_inc   = 1'b0;
        drn_clr    = 1'b0;
        drn_inc    = 1'b0;
        share_cen  = CEN_OFF;
        share_wen  = WEN_READ;
        share_addr = '0;
        O_SEL      = '0;

        if (EN) begin
            // Read issued now -> data valid on the next enabled cycle.
            w_pend_d = (state_q == S_LOAD_W);
            a_pend_d = (state_q == S_LOAD_I);
            if (state_q == S_LOAD_W) begin
                w_row_d = row_cnt;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (START) begin
                        if (NUM_TILES != '0) begin
                            iaddr_d  = IADDR;
                            waddr_d  = WADDR;
                            oaddr_d  = OADDR;
                            ntiles_d = NUM_TILES;
                            row_clr  = 1'b1;
                            tile_clr = 1'b1;
                            state_d  = S_LOAD_W;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_LOAD_W: begin
                    share_cen  = CEN_ON;
                    share_addr = waddr_q + AW'(row_cnt);
                    row_inc    = 1'b1;
                    if (row_last) begin
                        state_d = S_LOAD_I;
                    end
                end
                S_LOAD_I: begin
                    share_cen  = CEN_ON;
                    share_addr = iaddr_q + offset;
                    row_inc    = 1'b1;
                    if (row_last) begin
                        drn_clr = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Latency counting begins after the last A_VALID cycle.
                    if (!a_pend_q) begin
                        if (drn_last) begin
                            state_d = S_WRITE_O;
                        end else begin
                            drn_inc = 1'b1;
                        end
                    end
                end
                S_WRITE_O: begin
                    share_cen  = CEN_ON;
                    share_wen  = WEN_WRITE;
                    share_addr = oaddr_q + offset;
                    O_SEL      = row_cnt;
                    row_inc    = 1'b1;
                    if (row_last) begin
                        tile_inc = 1'b1;
                        state_d  = tile_last ? S_DONE : S_LOAD_I;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            iaddr_q  <= '0;
            waddr_q  <= '0;
            oaddr_q  <= '0;
            ntiles_q <= '0;
            w_pend_q <= 1'b0;
            w_row_q  <= '0;
            a_pend_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            iaddr_q  <= iaddr_d;
            waddr_q  <= waddr_d;
            oaddr_q  <= oaddr_d;
            ntiles_q <= ntiles_d;
            w_pend_q <= w_pend_d;
            w_row_q  <= w_row_d;
            a_pend_q <= a_pend_d;
        end
    end

    assign STATE   = state_q;
    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = (state_q == S_DONE) && EN;
    assign W_EN    = w_pend_q && EN;
    assign W_ROW   = w_row_q;
    assign A_VALID = a_pend_q && EN;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (EN && (state_q == S_IDLE) && START) begin
            perf_d = '0;
        end else if (EN && BUSY && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign PERF_CYCLES = perf_q;
`else
    // Cycle counter not built.
`endif

endmodule
